// File: rtl/sram_bus_arbiter_if.sv
// Signal bundle between the CPU fetch/data ports, the SRAM arbiter and the board SRAM pins.
// The arbiter uses the slave view; the CPU/pin side uses the master view.
interface sram_bus_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_sel;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    logic [19:0] ram_addr;
    logic [3:0]  ram_be_n;
    logic [1:0]  ram_ce_n;
    logic        ram_oe_n;
    logic        ram_we_n;
    logic [31:0] ram_dout;
    logic        ram_dout_en;
    logic [31:0] base_ram_din;
    logic [31:0] ext_ram_din;

    modport slave (
        input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_sel, mem_wdata,
               base_ram_din, ext_ram_din,
        output if_rdata, if_ack, mem_rdata, mem_ack,
               ram_addr, ram_be_n, ram_ce_n, ram_oe_n, ram_we_n, ram_dout, ram_dout_en
    );

    modport master (
        output if_req, if_addr, mem_req, mem_we, mem_addr, mem_sel, mem_wdata,
               base_ram_din, ext_ram_din,
        input  if_rdata, if_ack, mem_rdata, mem_ack,
               ram_addr, ram_be_n, ram_ce_n, ram_oe_n, ram_we_n, ram_dout, ram_dout_en
    );
endinterface

// File: rtl/sram_bus_arbiter.sv
// Shares the base/ext SRAM pair between the IF and MEM ports (MEM wins), with registered
// strobes, programmable wait states and a one-cycle ack per access.
//
// state    | meaning
// IDLE     | strobes off, grant sampled here
// RD       | CE/OE low for RD_WAIT cycles, data captured on the last one
// WR_SETUP | CE low and data driven before WE falls
// WR_PULSE | WE low for WR_WAIT cycles
// WR_HOLD  | WE high, CE and data held
// DONE     | strobes off, owner's ack high (bus turnaround)
module sram_bus_arbiter #(
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 2
) (
    input  logic clk,
    input  logic rst,
    sram_bus_arbiter_if.slave bus
);

    typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE} state_t;

    localparam logic [3:0] RD_CNT = 4'(RD_WAIT - 1);
    localparam logic [3:0] WR_CNT = 4'(WR_WAIT - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        own_mem_q, own_mem_d;
    logic [20:0] addr_q, addr_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  ce_n_q, ce_n_d;
    logic        oe_n_q, oe_n_d;
    logic        we_n_q, we_n_d;
    logic [3:0]  be_n_q, be_n_d;
    logic        dout_en_q, dout_en_d;
    logic        if_ack_q, if_ack_d;
    logic        mem_ack_q, mem_ack_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic [31:0] din;
    logic [1:0]  bank_ce_n;
    logic        unused_addr_bits;

    // Upper and byte-offset address bits are decoded upstream.
    assign unused_addr_bits = ^{bus.if_addr[31:23], bus.if_addr[1:0],
                                bus.mem_addr[31:23], bus.mem_addr[1:0]};

    assign din = addr_q[20] ? bus.ext_ram_din : bus.base_ram_din;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        own_mem_d   = own_mem_q;
        addr_d      = addr_q;
        sel_d       = sel_q;
        wdata_d     = wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        case (state_q)
            IDLE: begin
                if (bus.mem_req) begin
                    own_mem_d = 1'b1;
                    addr_d    = bus.mem_addr[22:2];
                    sel_d     = bus.mem_sel;
                    wdata_d   = bus.mem_wdata;
                    if (bus.mem_we) begin
                        state_d = WR_SETUP;
                    end else begin
                        state_d = RD;
                        cnt_d   = RD_CNT;
                    end
                end else if (bus.if_req) begin
                    own_mem_d = 1'b0;
                    addr_d    = bus.if_addr[22:2];
                    sel_d     = 4'hF;
                    state_d   = RD;
                    cnt_d     = RD_CNT;
                end
            end
            RD: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    if (own_mem_q) mem_rdata_d = din;
                    else           if_rdata_d  = din;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WR_SETUP: begin
                state_d = WR_PULSE;
                cnt_d   = WR_CNT;
            end
            WR_PULSE: begin
                if (cnt_q == 4'd0) state_d = WR_HOLD;
                else               cnt_d   = cnt_q - 4'd1;
            end
            WR_HOLD: state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes are decoded from the next state so the pins change on the same edge as the state.
    assign bank_ce_n = addr_d[20] ? 2'b01 : 2'b10;

    always_comb begin
        ce_n_d    = 2'b11;
        oe_n_d    = 1'b1;
        we_n_d    = 1'b1;
        be_n_d    = 4'hF;
        dout_en_d = 1'b0;
        if_ack_d  = 1'b0;
        mem_ack_d = 1'b0;
        case (state_d)
            RD: begin
                ce_n_d = bank_ce_n;
                oe_n_d = 1'b0;
                be_n_d = ~sel_d;
            end
            WR_SETUP, WR_HOLD: begin
                ce_n_d    = bank_ce_n;
                dout_en_d = 1'b1;
            end
            WR_PULSE: begin
                ce_n_d    = bank_ce_n;
                dout_en_d = 1'b1;
                we_n_d    = 1'b0;
                be_n_d    = ~sel_d;
            end
            DONE: begin
                mem_ack_d = own_mem_d;
                if_ack_d  = ~own_mem_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            own_mem_q   <= 1'b0;
            addr_q      <= '0;
            sel_q       <= 4'h0;
            wdata_q     <= '0;
            ce_n_q      <= 2'b11;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            be_n_q      <= 4'hF;
            dout_en_q   <= 1'b0;
            if_ack_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            own_mem_q   <= own_mem_d;
            addr_q      <= addr_d;
            sel_q       <= sel_d;
            wdata_q     <= wdata_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            be_n_q      <= be_n_d;
            dout_en_q   <= dout_en_d;
            if_ack_q    <= if_ack_d;
            mem_ack_q   <= mem_ack_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign bus.ram_addr    = addr_q[19:0];
    assign bus.ram_dout    = wdata_q;
    assign bus.ram_ce_n    = ce_n_q;
    assign bus.ram_oe_n    = oe_n_q;
    assign bus.ram_we_n    = we_n_q;
    assign bus.ram_be_n    = be_n_q;
    assign bus.ram_dout_en = dout_en_q;
    assign bus.if_ack      = if_ack_q;
    assign bus.mem_ack     = mem_ack_q;
    assign bus.if_rdata    = if_rdata_q;
    assign bus.mem_rdata   = mem_rdata_q;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Bench for sram_bus_arbiter: behavioural SRAM on the pins, a word-array reference memory,
// a vector table, hand-written corner sequences and a randomized access stream.
`timescale 1ns/1ps
module tb_sram_bus_arbiter;

    localparam int RDW = 2;
    localparam int WRW = 2;

    typedef struct {
        bit          is_mem;
        bit          we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_bus_arbiter_if bus ();
    sram_bus_arbiter_if bus2 ();

    sram_bus_arbiter #(.RD_WAIT(RDW), .WR_WAIT(WRW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    sram_bus_arbiter #(.RD_WAIT(1), .WR_WAIT(1)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

    int n_chk = 0;
    int n_err = 0;
    int proto_viol = 0;
    int cyc = 0;
    int last_ack_cyc = 0;
    bit mem_inited = 1'b0;

    logic [31:0] base_mem [256];
    logic [31:0] ext_mem  [256];
    logic [31:0] ref_base [256];
    logic [31:0] ref_ext  [256];

    function automatic logic [31:0] seed_word(input bit bank, input int i);
        if (!bank && i == 4) return 32'hDEADBEEF;
        if (!bank && i == 5) return 32'h55555555;
        if (bank && i == 2)  return 32'hAAAAAAAA;
        return (bank ? 32'hE0000000 : 32'hB0000000) | 32'(i);
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] addr);
        return addr[22] ? ref_ext[addr[9:2]] : ref_base[addr[9:2]];
    endfunction

    // Behavioural SRAM pair: asynchronous read, byte writes while WE is low.
    assign bus.base_ram_din  = base_mem[bus.ram_addr[7:0]];
    assign bus.ext_ram_din   = ext_mem[bus.ram_addr[7:0]];
    assign bus2.base_ram_din = 32'hCAFE0001;
    assign bus2.ext_ram_din  = 32'hCAFE0002;

    always @(negedge clk) begin
        if (rst && !mem_inited) begin
            for (int i = 0; i < 256; i++) begin
                base_mem[i] = seed_word(1'b0, i);
                ext_mem[i]  = seed_word(1'b1, i);
            end
            mem_inited = 1'b1;
        end else if (!rst && bus.ram_we_n === 1'b0) begin
            for (int b = 0; b < 4; b++) begin
                if (!bus.ram_be_n[b]) begin
                    if (!bus.ram_ce_n[0]) base_mem[bus.ram_addr[7:0]][8*b +: 8] = bus.ram_dout[8*b +: 8];
                    if (!bus.ram_ce_n[1]) ext_mem[bus.ram_addr[7:0]][8*b +: 8]  = bus.ram_dout[8*b +: 8];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.ram_ce_n === 2'b00
                || (bus.ram_we_n === 1'b0 && (bus.ram_ce_n === 2'b11 || bus.ram_dout_en !== 1'b1 || bus.ram_oe_n !== 1'b1))
                || (bus.ram_oe_n === 1'b0 && bus.ram_dout_en !== 1'b0)
                || (bus.if_ack === 1'b1 && bus.mem_ack === 1'b1))
                proto_viol++;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Issues one access from an IDLE cycle (cycle 1) and checks latency, strobes and data.
    // Returns #1 after the edge that enters the following IDLE cycle.
    task automatic run_access(input string tag, input bit is_mem, input bit we, input logic [31:0] addr,
                              input logic [3:0] sel, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input bit hold);
        int k, exp_lat, oe_cyc, we_cyc, den_cyc, bad;
        logic got;
        logic [1:0] exp_ce;
        logic [3:0] exp_be;
        exp_ce  = addr[22] ? 2'b01 : 2'b10;
        exp_be  = is_mem ? ~sel : 4'h0;
        exp_lat = (is_mem && we) ? WRW + 4 : RDW + 2;
        oe_cyc = 0; we_cyc = 0; den_cyc = 0; bad = 0;
        if (is_mem) begin
            bus.mem_req = 1'b1; bus.mem_we = we; bus.mem_addr = addr;
            bus.mem_sel = sel;  bus.mem_wdata = wdata;
        end else begin
            bus.if_req = 1'b1; bus.if_addr = addr;
        end
        k = 1;
        got = 1'b0;
        while (!got && k < 40) begin
            @(posedge clk); #1;
            k++;
            if (bus.ram_ce_n !== 2'b11) begin
                if (bus.ram_ce_n !== exp_ce) bad++;
                if (bus.ram_addr !== addr[21:2]) bad++;
            end
            if (bus.ram_oe_n === 1'b0) begin
                oe_cyc++;
                if (bus.ram_be_n !== exp_be) bad++;
            end
            if (bus.ram_we_n === 1'b0) begin
                we_cyc++;
                if (bus.ram_be_n !== exp_be) bad++;
            end
            if (bus.ram_dout_en === 1'b1) den_cyc++;
            got = is_mem ? bus.mem_ack : bus.if_ack;
        end
        chk({tag, ".lat"}, 32'(k), 32'(exp_lat));
        if (got === 1'b1) begin
            last_ack_cyc = cyc;
            chk({tag, ".done_ce_n"}, 32'(bus.ram_ce_n), 32'h3);
            chk({tag, ".other_ack"}, 32'(is_mem ? bus.if_ack : bus.mem_ack), 32'h0);
            chk({tag, ".decode"}, 32'(bad), 32'h0);
            if (is_mem && we) begin
                chk({tag, ".we_width"}, 32'(we_cyc), 32'(WRW));
                chk({tag, ".dout_en_width"}, 32'(den_cyc), 32'(WRW + 2));
                chk({tag, ".oe_width"}, 32'(oe_cyc), 32'h0);
                for (int b = 0; b < 4; b++) begin
                    if (sel[b]) begin
                        if (addr[22]) ref_ext[addr[9:2]][8*b +: 8]  = wdata[8*b +: 8];
                        else          ref_base[addr[9:2]][8*b +: 8] = wdata[8*b +: 8];
                    end
                end
            end else begin
                chk({tag, ".oe_width"}, 32'(oe_cyc), 32'(RDW));
                chk({tag, ".dout_en_width"}, 32'(den_cyc), 32'h0);
                chk({tag, ".rdata"}, is_mem ? bus.mem_rdata : bus.if_rdata, exp_rdata);
            end
        end
        if (!hold) begin
            bus.mem_req = 1'b0;
            bus.if_req  = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t vt[9];
        int k, t_mem, t_if, oe, wec, den;
        logic got_if_early;
        int acks[3];
        logic [31:0] a;

        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_addr = '0; bus.mem_sel = 4'h0; bus.mem_wdata = '0;
        bus2.if_req = 1'b0; bus2.if_addr = '0;
        bus2.mem_req = 1'b0; bus2.mem_we = 1'b0; bus2.mem_addr = '0; bus2.mem_sel = 4'h0; bus2.mem_wdata = '0;
        for (int i = 0; i < 256; i++) begin
            ref_base[i] = seed_word(1'b0, i);
            ref_ext[i]  = seed_word(1'b1, i);
        end

        vt[0] = '{1'b0, 1'b0, 32'h0000_0010, 4'hF,    32'h0,         32'hDEADBEEF};
        vt[1] = '{1'b1, 1'b1, 32'h0040_0008, 4'b0011, 32'h12345678,  32'h0};
        vt[2] = '{1'b1, 1'b0, 32'h0040_0008, 4'hF,    32'h0,         32'hAAAA5678};
        vt[3] = '{1'b1, 1'b1, 32'h0000_0014, 4'h0,    32'hFFFFFFFF,  32'h0};
        vt[4] = '{1'b1, 1'b0, 32'h0000_0014, 4'hF,    32'h0,         32'h55555555};
        vt[5] = '{1'b0, 1'b0, 32'hFF80_0013, 4'hF,    32'h0,         32'hDEADBEEF};
        vt[6] = '{1'b1, 1'b0, 32'hC040_0003, 4'b1010, 32'h0,         32'hE0000000};
        vt[7] = '{1'b1, 1'b1, 32'h0040_0000, 4'hF,    32'h0BADF00D,  32'h0};
        vt[8] = '{1'b0, 1'b0, 32'h0040_0000, 4'hF,    32'h0,         32'h0BADF00D};

        repeat (3) @(posedge clk);
        #1;
        chk("rst.ce_n", 32'(bus.ram_ce_n), 32'h3);
        chk("rst.oe_n", 32'(bus.ram_oe_n), 32'h1);
        chk("rst.we_n", 32'(bus.ram_we_n), 32'h1);
        chk("rst.be_n", 32'(bus.ram_be_n), 32'hF);
        chk("rst.addr", 32'(bus.ram_addr), 32'h0);
        chk("rst.dout", bus.ram_dout, 32'h0);
        chk("rst.dout_en", 32'(bus.ram_dout_en), 32'h0);
        chk("rst.acks", 32'({bus.if_ack, bus.mem_ack}), 32'h0);
        chk("rst.if_rdata", bus.if_rdata, 32'h0);
        chk("rst.mem_rdata", bus.mem_rdata, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++)
            run_access($sformatf("vec%0d", i), vt[i].is_mem, vt[i].we, vt[i].addr,
                       vt[i].sel, vt[i].wdata, vt[i].exp_rdata, 1'b0);

        // Back-to-back IF reads with the request held across DONE.
        for (int i = 0; i < 3; i++) begin
            a = 32'(i * 4);
            run_access($sformatf("b2b%0d", i), 1'b0, 1'b0, a, 4'hF, 32'h0, ref_word(a), i != 2);
            acks[i] = last_ack_cyc;
        end
        chk("b2b.gap1", 32'(acks[1] - acks[0]), 32'(RDW + 2));
        chk("b2b.gap2", 32'(acks[2] - acks[1]), 32'(RDW + 2));

        // Simultaneous requests: MEM (ext read) first, IF one access later.
        bus.if_req = 1'b1;  bus.if_addr = 32'h0000_0008;
        bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_addr = 32'h0040_0004; bus.mem_sel = 4'hF;
        k = 1; t_mem = 0; t_if = 0; got_if_early = 1'b0;
        while (t_if == 0 && k < 40) begin
            @(posedge clk); #1;
            k++;
            if (bus.mem_ack === 1'b1 && t_mem == 0) begin
                t_mem = k;
                chk("simul.mem_rdata", bus.mem_rdata, ref_word(32'h0040_0004));
                bus.mem_req = 1'b0;
            end
            if (bus.if_ack === 1'b1) begin
                if (t_mem == 0) got_if_early = 1'b1;
                t_if = k;
                chk("simul.if_rdata", bus.if_rdata, ref_word(32'h0000_0008));
            end
        end
        chk("simul.mem_lat", 32'(t_mem), 32'(RDW + 2));
        chk("simul.if_gap", 32'(t_if - t_mem), 32'(RDW + 2));
        chk("simul.if_before_mem", 32'(got_if_early), 32'h0);
        bus.if_req = 1'b0; bus.mem_req = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of the write pulse.
        bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_addr = 32'h0000_0020;
        bus.mem_sel = 4'hF; bus.mem_wdata = 32'h600DCAFE;
        k = 0;
        while (bus.ram_we_n !== 1'b0 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("rstmid.reached_pulse", 32'(bus.ram_we_n), 32'h0);
        #2 rst = 1'b1;
        #1;
        chk("rstmid.we_n", 32'(bus.ram_we_n), 32'h1);
        chk("rstmid.ce_n", 32'(bus.ram_ce_n), 32'h3);
        chk("rstmid.dout_en", 32'(bus.ram_dout_en), 32'h0);
        bus.mem_req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rstmid.no_ack", 32'(bus.mem_ack), 32'h0);
        run_access("rstmid.rewrite", 1'b1, 1'b1, 32'h0000_0020, 4'hF, 32'h600DCAFE, 32'h0, 1'b0);
        run_access("rstmid.readback", 1'b1, 1'b0, 32'h0000_0020, 4'hF, 32'h0, 32'h600DCAFE, 1'b0);

        // Randomized stream against the reference memory.
        for (int i = 0; i < 80; i++) begin
            bit m, w;
            logic [3:0] s;
            m = 1'($urandom_range(0, 1));
            w = m & 1'($urandom_range(0, 1));
            a = $urandom & ~32'h0000_03C0;
            s = 4'($urandom);
            run_access($sformatf("rnd%0d", i), m, w, a, s, $urandom, ref_word(a), 1'b0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        // Minimum wait-state instance.
        bus2.if_req = 1'b1; bus2.if_addr = 32'h0000_0010;
        k = 1; oe = 0;
        while (bus2.if_ack !== 1'b1 && k < 20) begin
            @(posedge clk); #1;
            k++;
            if (bus2.ram_oe_n === 1'b0) oe++;
        end
        chk("w1.rd_lat", 32'(k), 32'd3);
        chk("w1.oe_width", 32'(oe), 32'd1);
        chk("w1.rdata", bus2.if_rdata, 32'hCAFE0001);
        bus2.if_req = 1'b0;
        @(posedge clk); #1;
        bus2.mem_req = 1'b1; bus2.mem_we = 1'b1; bus2.mem_addr = 32'h0040_0000;
        bus2.mem_sel = 4'hF; bus2.mem_wdata = 32'h1;
        k = 1; wec = 0; den = 0;
        while (bus2.mem_ack !== 1'b1 && k < 20) begin
            @(posedge clk); #1;
            k++;
            if (bus2.ram_we_n === 1'b0) wec++;
            if (bus2.ram_dout_en === 1'b1) den++;
        end
        chk("w1.wr_lat", 32'(k), 32'd5);
        chk("w1.we_width", 32'(wec), 32'd1);
        chk("w1.dout_en_width", 32'(den), 32'd3);
        bus2.mem_req = 1'b0;
        @(posedge clk); #1;

        chk("protocol_violations", 32'(proto_viol), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
